aes_round_mix_seq: RTL and testbench

Multi-cycle, column-serial AES linear-layer stage: accepts a full 128-bit state and applies ShiftRows then MixColumns (encrypt), or InvShiftRows then InvMixColumns (decrypt). It sits directly upstream of, and instantiates, the single-column `aes_mixcolumn` unit, sequencing one column per cycle through it. It returns the assembled 128-bit result over a valid/ready handshake. A per-transaction bypass skips MixColumns so the same block serves the final round.

---
 rtl/aes_round_mix_seq.sv | 131 +++++++++++++
 tb/tb_aes_round_mix_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_mix_seq.sv
// Column-serial AES linear layer: (Inv)ShiftRows on accept, then one column per
// cycle through aes_mixcolumn, result returned over a valid/ready handshake.

module aes_mixcolumn (
  input  logic [31:0] col_in,
  input  logic        dec,
  output logic [31:0] col_out
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // p is the byte on this output's row; q, s, t follow it cyclically down the column.
  function automatic logic [7:0] row_byte(input logic [7:0] p, input logic [7:0] q,
                                          input logic [7:0] s, input logic [7:0] t,
                                          input logic inv);
    logic [7:0] p2, p4, p8, q2, q4, q8, s2, s4, s8, t2, t4, t8;
    p2 = xt(p); p4 = xt(p2); p8 = xt(p4);
    q2 = xt(q); q4 = xt(q2); q8 = xt(q4);
    s2 = xt(s); s4 = xt(s2); s8 = xt(s4);
    t2 = xt(t); t4 = xt(t2); t8 = xt(t4);
    if (inv)
      return (p8 ^ p4 ^ p2) ^ (q8 ^ q2 ^ q) ^ (s8 ^ s4 ^ s) ^ (t8 ^ t);
    else
      return p2 ^ (q2 ^ q) ^ s ^ t;
  endfunction

  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    a0 = col_in[7:0];
    a1 = col_in[15:8];
    a2 = col_in[23:16];
    a3 = col_in[31:24];
    col_out = {row_byte(a3, a0, a1, a2, dec),
               row_byte(a2, a3, a0, a1, dec),
               row_byte(a1, a2, a3, a0, dec),
               row_byte(a0, a1, a2, a3, dec)};
  end

endmodule

module aes_round_mix_seq (
  input  logic         g_clk,
  input  logic         g_reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_dec,
  input  logic         in_mix,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; out_valid and out_state hold steady until that edge, and in_ready/out_valid
  // depend only on the registered FSM state.

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         state;
  logic [1:0]   col;
  logic         dec_q;
  logic         mix_q;
  logic [127:0] sh_state;
  logic [6:0]   col_base;
  logic [31:0]  mc_in;
  logic [31:0]  mc_out;

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] t;
    int src;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        t[32*c + 8*r +: 8] = s[32*src + 8*r +: 8];
      end
    end
    return t;
  endfunction

  assign col_base = {col, 5'b0};
  assign mc_in    = sh_state[col_base +: 32];

  aes_mixcolumn u_mixcolumn (
    .col_in  (mc_in),
    .dec     (dec_q),
    .col_out (mc_out)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state     <= IDLE;
      col       <= 2'd0;
      dec_q     <= 1'b0;
      mix_q     <= 1'b0;
      sh_state  <= '0;
      out_state <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_state <= shift_rows(in_state, in_dec);
            dec_q    <= in_dec;
            mix_q    <= in_mix;
            col      <= 2'd0;
            state    <= RUN;
          end
        end
        RUN: begin
          out_state[col_base +: 32] <= mix_q ? mc_out : mc_in;
          col <= col + 2'd1;
          if (col == 2'd3) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_mix_seq.sv
// Bench for aes_round_mix_seq: directed and random transactions checked against
// a byte-matrix / GF(2^8) reference model.

module tb_aes_round_mix_seq;

  logic         g_clk;
  logic         g_reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_dec;
  logic         in_mix;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int n_checks;
  int n_fail;

  aes_round_mix_seq dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_dec    (in_dec),
    .in_mix    (in_mix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // GF(2^8) multiply, shift-and-add reduced by 0x11b
  function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
    int aa;
    int p;
    aa = int'(a);
    p  = 0;
    for (int i = 0; i < 4; i++) begin
      if (((k >> i) & 1) == 1) p = p ^ aa;
      aa = aa << 1;
      if ((aa & 256) != 0) aa = aa ^ 'h11b;
    end
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] s, input logic dec, input logic mix);
    logic [7:0] b [4][4];
    logic [7:0] t [4][4];
    logic [7:0] acc;
    logic [127:0] res;
    int fwd [4];
    int inv [4];
    int coef;
    fwd = '{2, 3, 1, 1};
    inv = '{14, 11, 13, 9};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[r][c] = s[32*c + 8*r +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = dec ? b[r][(c - r + 4) % 4] : b[r][(c + r) % 4];
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (mix) begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) begin
            coef = dec ? inv[(k - r + 4) % 4] : fwd[(k - r + 4) % 4];
            acc  = acc ^ gmul(t[k][c], coef);
          end
        end else begin
          acc = t[r][c];
        end
        res[32*c + 8*r +: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Full transaction; out_ready stays low for `hold` cycles after out_valid rises.
  task automatic run_txn(input string tag, input logic [127:0] st, input logic dec,
                         input logic mix, input logic [127:0] exp, input int hold,
                         output logic [127:0] res);
    int k;
    check({tag, ".in_ready_idle"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_state = st;
    in_dec   = dec;
    in_mix   = mix;
    @(negedge g_clk);
    in_valid = 1'b0;
    in_state = rand128();
    in_dec   = ~dec;
    in_mix   = ~mix;
    check({tag, ".busy_run"}, 128'({busy, in_ready, out_valid}), 128'b100);
    k = 0;
    do begin
      @(negedge g_clk);
      k++;
    end while (out_valid !== 1'b1 && k < 20);
    check({tag, ".latency"}, 128'(k), 128'd4);
    check({tag, ".out_state"}, out_state, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_state = rand128();
      @(negedge g_clk);
      check({tag, ".hold_valid_ready"}, 128'({out_valid, in_ready, busy}), 128'b101);
      check({tag, ".hold_state"}, out_state, exp);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge g_clk);
    out_ready = 1'b0;
    check({tag, ".after_hs"}, 128'({out_valid, in_ready, busy}), 128'b010);
    check({tag, ".state_kept"}, out_state, exp);
    res = out_state;
  endtask

  logic [127:0] st, r1, r2, exp_v;
  logic         d, m;
  logic         saw_valid;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    g_reset   = 1'b1;
    in_valid  = 1'b1;
    in_state  = rand128();
    in_dec    = 1'b0;
    in_mix    = 1'b1;
    out_ready = 1'b0;

    // Reset held two cycles with in_valid asserted
    repeat (2) @(negedge g_clk);
    g_reset  = 1'b0;
    in_valid = 1'b0;
    check("reset.flags", 128'({in_ready, out_valid, busy}), 128'b100);
    check("reset.out_state", out_state, 128'd0);
    @(negedge g_clk);
    check("reset.no_accept", 128'({in_ready, busy}), 128'b10);

    // ShiftRows only, both directions
    st = 128'h0f0e0d0c0b0a09080706050403020100;
    run_txn("shift_fwd", st, 1'b0, 1'b0, 128'h0b06010c07020d08030e09040f0a0500, 0, r1);
    check("shift_fwd.model", r1, ref_model(st, 1'b0, 1'b0));
    run_txn("shift_inv_of_fwd", r1, 1'b1, 1'b0, st, 0, r2);

    // MixColumns / InvMixColumns known vectors
    run_txn("mix_fwd", {4{32'h455313db}}, 1'b0, 1'b1, {4{32'hbca14d8e}}, 0, r1);
    run_txn("mix_inv", {4{32'hbca14d8e}}, 1'b1, 1'b1, {4{32'h455313db}}, 0, r1);

    // Random round trip through ShiftRows then InvShiftRows
    st = rand128();
    run_txn("rt_fwd", st, 1'b0, 1'b0, ref_model(st, 1'b0, 1'b0), 0, r1);
    run_txn("rt_inv", r1, 1'b1, 1'b0, st, 0, r2);

    // Random transactions against the model
    for (int i = 0; i < 8; i++) begin
      st = rand128();
      d  = 1'($urandom_range(0, 1));
      m  = 1'($urandom_range(0, 1));
      run_txn("rand", st, d, m, ref_model(st, d, m), int'($urandom_range(0, 3)), r1);
    end

    // Backpressure for 10 cycles
    st = rand128();
    run_txn("backpressure", st, 1'b0, 1'b1, ref_model(st, 1'b0, 1'b1), 10, r1);

    // Reset sampled at E2 aborts the transaction
    st = rand128();
    in_valid = 1'b1;
    in_state = st;
    in_dec   = 1'b0;
    in_mix   = 1'b1;
    @(negedge g_clk);
    in_valid = 1'b0;
    @(negedge g_clk);
    g_reset = 1'b1;
    @(negedge g_clk);
    g_reset = 1'b0;
    check("midreset.flags", 128'({in_ready, out_valid, busy}), 128'b100);
    check("midreset.out_state", out_state, 128'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge g_clk);
      if (out_valid === 1'b1 || busy === 1'b1) saw_valid = 1'b1;
    end
    check("midreset.no_out_valid", 128'(saw_valid), 128'd0);
    st = rand128();
    exp_v = ref_model(st, 1'b1, 1'b1);
    run_txn("after_reset", st, 1'b1, 1'b1, exp_v, 1, r1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
    $fatal(1, "watchdog");
  end

endmodule
